// File: rtl/ret_stack_ctrl_if.sv
// ret_stack_ctrl_if: push/pop link between the return-stack controller and the hardware Stack.
interface ret_stack_ctrl_if #(parameter int ADDR_WIDTH = 12);
    logic                  push_sig;
    logic                  pop_sig;
    logic [ADDR_WIDTH-1:0] push_data;
    logic                  overflow;
    logic [ADDR_WIDTH-1:0] pop_data;
    modport master (output push_sig, pop_sig, push_data, input overflow, pop_data);
    modport slave  (input push_sig, pop_sig, push_data, output overflow, pop_data);
endinterface

// File: rtl/ret_stack_ctrl.sv
// ret_stack_ctrl: drives a hardware Stack as a return-address stack, stalling
// the front end on returns and flagging overflow/underflow from a local count.
module ret_stack_ctrl #(
    parameter int ADDR_WIDTH = 12,
    parameter int DEPTH      = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         is_call,
    input  logic                         is_ret,
    input  logic [ADDR_WIDTH-1:0]        pc,
    ret_stack_ctrl_if.master             sb,
    output logic                         stall,
    output logic                         redirect,
    output logic [ADDR_WIDTH-1:0]        redirect_pc,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         ovf_err,
    output logic                         unf_err,
    output logic                         ret_fault
);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [1:0] IDLE = 2'd0, POP = 2'd1, WAIT = 2'd2, REDIR = 2'd3;

    logic [1:0] state;

    assign stall = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            sb.push_sig <= 1'b0;
            sb.pop_sig  <= 1'b0;
            sb.push_data <= '0;
            redirect    <= 1'b0;
            redirect_pc <= '0;
            count       <= '0;
            ovf_err     <= 1'b0;
            unf_err     <= 1'b0;
            ret_fault   <= 1'b0;
        end else begin
            sb.push_sig <= 1'b0;
            sb.pop_sig  <= 1'b0;
            redirect    <= 1'b0;
            ret_fault   <= 1'b0;
            if (sb.overflow) ovf_err <= 1'b1;
            case (state)
                IDLE: begin
                    if (is_call && is_ret) begin
                        ret_fault <= 1'b1;
                    end else if (is_call) begin
                        // the push goes out even when full; the Stack decides what to drop
                        sb.push_sig  <= 1'b1;
                        sb.push_data <= pc + ADDR_WIDTH'(1);
                        if (count == CW'(DEPTH)) ovf_err <= 1'b1;
                        else count <= count + CW'(1);
                    end else if (is_ret) begin
                        if (count == '0) begin
                            unf_err   <= 1'b1;
                            ret_fault <= 1'b1;
                        end else begin
                            sb.pop_sig <= 1'b1;
                            count      <= count - CW'(1);
                            state      <= POP;
                        end
                    end
                end
                POP: state <= WAIT;
                WAIT: begin
                    // pop_data is valid now, one cycle after the Stack sampled pop_sig
                    redirect_pc <= sb.pop_data;
                    redirect    <= 1'b1;
                    state       <= REDIR;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
